// File: rtl/f3_gpu_pkg.sv
// Shared definitions for the f3_gpu image-view engine: command codes, FSM states,
// rotation encoding and the wrapping image-index step.
package f3_gpu_pkg;

  localparam logic [2:0] CMD_NOP        = 3'd0;
  localparam logic [2:0] CMD_PREV       = 3'd1;
  localparam logic [2:0] CMD_NEXT       = 3'd2;
  localparam logic [2:0] CMD_ROT_CW     = 3'd3;
  localparam logic [2:0] CMD_NEGATE     = 3'd4;
  localparam logic [2:0] CMD_ROT_CCW    = 3'd5;
  localparam logic [2:0] CMD_MIRROR     = 3'd6;
  localparam logic [2:0] CMD_RESET_VIEW = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ANIM_PREV = 2'd1,
    ST_ANIM_NEXT = 2'd2
  } state_t;

  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

  // Step an image index by one in either direction, wrapping within [0, count-1].
  function automatic int unsigned img_wrap(input int unsigned idx, input logic dec,
                                           input int unsigned count);
    int unsigned res;
    if (dec) begin
      res = (idx == 32'd0) ? count - 32'd1 : idx - 32'd1;
    end else begin
      res = (idx >= count - 32'd1) ? 32'd0 : idx + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/f3_gpu_axis_map.sv
// Maps one 10-bit display coordinate onto a clamped image cell index along one axis.
module f3_gpu_axis_map #(
  parameter int unsigned ORIGIN   = 112,
  parameter int unsigned CELL     = 40,
  parameter int unsigned IMG_LOG2 = 4
) (
  input  logic [9:0]          coord,
  output logic [IMG_LOG2-1:0] idx
);

  localparam int unsigned M = (32'd1 << IMG_LOG2) - 32'd1;

  // Thresholds rise monotonically, so the last one reached is the cell; the loop bound clamps to M.
  always_comb begin
    idx = '0;
    for (int unsigned i = 32'd1; i <= M; i++) begin
      idx = ({22'd0, coord} >= ORIGIN + i * CELL) ? IMG_LOG2'(i) : idx;
    end
  end

endmodule

// File: rtl/f3_gpu.sv
// Image-view engine: display coordinate -> ROM cell address with rotate/mirror/negate,
// plus a timed wipe between images on PREV/NEXT, commanded over valid/ready.
module f3_gpu
  import f3_gpu_pkg::*;
#(
  parameter int unsigned IMG_LOG2   = 4,
  parameter int unsigned NUM_IMAGES = 8,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned X_ORIGIN   = 112,
  parameter int unsigned Y_ORIGIN   = 7,
  parameter int unsigned CELL_W     = 40,
  parameter int unsigned CELL_H     = 30,
  parameter int unsigned ANIM_DIV   = 16,
  localparam int unsigned IW = (NUM_IMAGES > 32'd1) ? $clog2(NUM_IMAGES) : 32'd1,
  localparam int unsigned AW = 2 * IMG_LOG2
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [2:0]         cmd,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic               busy,
  input  logic [19:0]        display_addr,
  input  logic [COLOR_W-1:0] pixel_data,
  output logic [AW-1:0]      pixel_addr,
  output logic [IW-1:0]      image_index,
  output logic [COLOR_W-1:0] display_data
);

  localparam int unsigned         PW         = (ANIM_DIV > 32'd1) ? $clog2(ANIM_DIV) : 32'd1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(ANIM_DIV - 32'd1);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(32'd1);
  localparam logic [AW-1:0]       ANIM_MAX   = '1;
  localparam logic [AW-1:0]       ANIM_ONE   = AW'(32'd1);
  localparam logic [IMG_LOG2-1:0] M_IDX      = '1;

  state_t              state_r;
  logic [IW-1:0]       cur_r, old_r, cur_dec_s, cur_inc_s, img_s;
  logic [1:0]          rot_r;
  logic                neg_r, mir_r, accept_s, step_s;
  logic [AW-1:0]       anim_r, addr_s;
  logic [PW-1:0]       presc_r;
  logic [IMG_LOG2-1:0] cx_s, cy_s, cx_r, cy_r, cxm_s, col_s, row_s;

  f3_gpu_axis_map #(.ORIGIN(X_ORIGIN), .CELL(CELL_W), .IMG_LOG2(IMG_LOG2)) u_map_x (
    .coord(display_addr[19:10]),
    .idx  (cx_s)
  );

  f3_gpu_axis_map #(.ORIGIN(Y_ORIGIN), .CELL(CELL_H), .IMG_LOG2(IMG_LOG2)) u_map_y (
    .coord(display_addr[9:0]),
    .idx  (cy_s)
  );

  assign accept_s  = cmd_valid & cmd_ready;
  assign step_s    = (presc_r == PRESC_LAST);
  assign cur_dec_s = IW'(img_wrap(32'(cur_r), 1'b1, NUM_IMAGES));
  assign cur_inc_s = IW'(img_wrap(32'(cur_r), 1'b0, NUM_IMAGES));

  // Command acceptance, view flags and the wipe-transition sequencer.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cur_r     <= '0;
      old_r     <= '0;
      rot_r     <= ROT_0;
      neg_r     <= 1'b0;
      mir_r     <= 1'b0;
      anim_r    <= '0;
      presc_r   <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          presc_r   <= '0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept_s) begin
            case (cmd)
              CMD_PREV: begin
                old_r     <= cur_r;
                cur_r     <= cur_dec_s;
                rot_r     <= ROT_0;
                neg_r     <= 1'b0;
                mir_r     <= 1'b0;
                anim_r    <= '0;
                state_r   <= ST_ANIM_PREV;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              CMD_NEXT: begin
                old_r     <= cur_r;
                cur_r     <= cur_inc_s;
                rot_r     <= ROT_0;
                neg_r     <= 1'b0;
                mir_r     <= 1'b0;
                anim_r    <= ANIM_MAX;
                state_r   <= ST_ANIM_NEXT;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              CMD_ROT_CW:  rot_r <= rot_r + 2'd1;
              CMD_ROT_CCW: rot_r <= rot_r - 2'd1;
              CMD_NEGATE:  neg_r <= ~neg_r;
              CMD_MIRROR:  mir_r <= ~mir_r;
              CMD_RESET_VIEW: begin
                rot_r <= ROT_0;
                neg_r <= 1'b0;
                mir_r <= 1'b0;
              end
              default: rot_r <= rot_r;
            endcase
          end
        end
        ST_ANIM_PREV: begin
          presc_r <= step_s ? '0 : presc_r + PRESC_ONE;
          if (step_s) begin
            if (anim_r == ANIM_MAX) begin
              state_r   <= ST_IDLE;
              anim_r    <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              anim_r <= anim_r + ANIM_ONE;
            end
          end
        end
        ST_ANIM_NEXT: begin
          presc_r <= step_s ? '0 : presc_r + PRESC_ONE;
          if (step_s) begin
            if (anim_r == '0) begin
              state_r   <= ST_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              anim_r <= anim_r - ANIM_ONE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Mirror first, then rotate the registered cell into a {col,row} ROM address.
  always_comb begin
    cxm_s = mir_r ? (M_IDX - cx_r) : cx_r;
    col_s = cxm_s;
    row_s = cy_r;
    case (rot_r)
      ROT_0:   begin col_s = cxm_s;        row_s = cy_r;          end
      ROT_90:  begin col_s = cy_r;         row_s = M_IDX - cxm_s; end
      ROT_180: begin col_s = M_IDX - cxm_s; row_s = M_IDX - cy_r; end
      ROT_270: begin col_s = M_IDX - cy_r; row_s = cxm_s;         end
      default: begin col_s = cxm_s;        row_s = cy_r;          end
    endcase
  end

  assign addr_s = {col_s, row_s};

  // The wipe boundary sits at anim: one side shows the outgoing image, the other the new one.
  always_comb begin
    case (state_r)
      ST_ANIM_PREV: img_s = (addr_s >= anim_r) ? old_r : cur_r;
      ST_ANIM_NEXT: img_s = (addr_s < anim_r) ? old_r : cur_r;
      default:      img_s = cur_r;
    endcase
  end

  // Cell registers, then the ROM address/image select stage and the output pixel.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cx_r         <= '0;
      cy_r         <= '0;
      pixel_addr   <= '0;
      image_index  <= '0;
      display_data <= '0;
    end else begin
      cx_r         <= cx_s;
      cy_r         <= cy_s;
      pixel_addr   <= addr_s;
      image_index  <= img_s;
      display_data <= neg_r ? ~pixel_data : pixel_data;
    end
  end

endmodule
